// File: rtl/component_update_tx_if.sv
// rtl/component_update_tx_if.sv - update-record stream between the reporter and the host bridge
interface component_update_tx_if;
   logic        rec_valid;
   logic        rec_ready;
   logic [1:0]  rec_id;
   logic [7:0]  rec_right;
   logic [5:0]  rec_width;
   logic [31:0] rec_value;

   modport master (
      output rec_valid,
      output rec_id,
      output rec_right,
      output rec_width,
      output rec_value,
      input  rec_ready
   );

   modport slave (
      input  rec_valid,
      input  rec_id,
      input  rec_right,
      input  rec_width,
      input  rec_value,
      output rec_ready
   );
endinterface

// File: rtl/component_update_tx.sv
// rtl/component_update_tx.sv - reports changed fields of a component state bus as (id, right, width, value) records
// A shadow of the last reported state limits each report to the chunks that differ from it.
module component_update_tx #(
   parameter int WIDTH  = 227,
   parameter int NCHUNK = 9
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [WIDTH-1:0]      comp_bus_i,
   input  logic                  sample_i,
   input  logic                  force_all_i,
   component_update_tx_if.master rec_if,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overrun_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic [7:0] chunk_right(input logic [3:0] k);
      case (k)
         4'd0:    chunk_right = 8'd1;
         4'd1:    chunk_right = 8'd3;
         4'd2:    chunk_right = 8'd67;
         4'd3:    chunk_right = 8'd35;
         4'd4:    chunk_right = 8'd131;
         4'd5:    chunk_right = 8'd99;
         4'd6:    chunk_right = 8'd195;
         4'd7:    chunk_right = 8'd163;
         4'd8:    chunk_right = 8'd226;
         default: chunk_right = 8'd1;
      endcase
   endfunction

   function automatic logic [5:0] chunk_width(input logic [3:0] k);
      case (k)
         4'd0, 4'd1: chunk_width = 6'd2;
         4'd8:       chunk_width = 6'd31;
         default:    chunk_width = 6'd32;
      endcase
   endfunction

   function automatic logic [7:0] chunk_lsb(input logic [3:0] k);
      chunk_lsb = chunk_right(k) - {2'b00, chunk_width(k)} + 8'd1;
   endfunction

   function automatic logic [WIDTH-1:0] chunk_mask(input logic [3:0] k);
      logic [WIDTH-1:0] ones;
      ones       = ({{(WIDTH-1){1'b0}}, 1'b1} << chunk_width(k)) - {{(WIDTH-1){1'b0}}, 1'b1};
      chunk_mask = ones << chunk_lsb(k);
   endfunction

   function automatic logic [31:0] chunk_value(input logic [WIDTH-1:0] bus, input logic [3:0] k);
      logic [32:0] fmask;
      fmask       = (33'd1 << chunk_width(k)) - 33'd1;
      chunk_value = 32'(bus >> chunk_lsb(k)) & fmask[31:0];
   endfunction

   logic [1:0]        state_q, state_d;
   logic [WIDTH-1:0]  snap_q, snap_d;
   logic [WIDTH-1:0]  shadow_q, shadow_d;
   logic [NCHUNK-1:0] dirty_q, dirty_d;
   logic [3:0]        cur_q, cur_d;
   logic              valid_q, valid_d;
   logic [1:0]        id_q, id_d;
   logic [7:0]        right_q, right_d;
   logic [5:0]        width_q, width_d;
   logic [31:0]       value_q, value_d;
   logic              overrun_q, overrun_d;

   logic [NCHUNK-1:0] diff;
   logic [3:0]        low_idx;
   logic              hs;

   // Change detection runs against the live bus so dirty is ready on the capture edge.
   always_comb begin
      diff = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         diff[k] = |((comp_bus_i ^ shadow_q) & chunk_mask(4'(k)));
      end
      low_idx = '0;
      for (int k = NCHUNK - 1; k >= 0; k--) begin
         if (dirty_q[k]) begin
            low_idx = 4'(k);
         end
      end
   end

   assign hs = valid_q && rec_if.rec_ready;

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      shadow_d  = shadow_q;
      dirty_d   = dirty_q;
      cur_d     = cur_q;
      valid_d   = valid_q;
      id_d      = id_q;
      right_d   = right_q;
      width_d   = width_q;
      value_d   = value_q;
      overrun_d = sample_i && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (sample_i) begin
               snap_d  = comp_bus_i;
               dirty_d = diff | {NCHUNK{force_all_i}};
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (dirty_q == '0) begin
               state_d = S_DONE;
            end else begin
               cur_d   = low_idx;
               id_d    = snap_q[1:0];
               right_d = chunk_right(low_idx);
               width_d = chunk_width(low_idx);
               value_d = chunk_value(snap_q, low_idx);
               valid_d = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (hs) begin
               shadow_d = (shadow_q & ~chunk_mask(cur_q)) | (snap_q & chunk_mask(cur_q));
               dirty_d  = dirty_q & ~(NCHUNK'(1) << cur_q);
               valid_d  = 1'b0;
               state_d  = S_SCAN;
            end
         end
         // One wind-down cycle carries the done pulse; busy stays high through it.
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         snap_q    <= '0;
         shadow_q  <= '0;
         dirty_q   <= '0;
         cur_q     <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         right_q   <= '0;
         width_q   <= '0;
         value_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         shadow_q  <= shadow_d;
         dirty_q   <= dirty_d;
         cur_q     <= cur_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         right_q   <= right_d;
         width_q   <= width_d;
         value_q   <= value_d;
         overrun_q <= overrun_d;
      end
   end

   assign rec_if.rec_valid = valid_q;
   assign rec_if.rec_id    = id_q;
   assign rec_if.rec_right = right_q;
   assign rec_if.rec_width = width_q;
   assign rec_if.rec_value = value_q;

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = (state_q == S_DONE);
   assign overrun_o = overrun_q;

endmodule
